// File: rtl/clb_config_chain.sv
// Configurable LUT block: config beats shift serially into a shadow register,
// then commit atomically into the active register that drives the LUT outputs.
module clb_config_chain #(
    parameter int ADDR_BITS = 4,
    parameter int LUTS      = 2,
    parameter int SHIFT_W   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_en,
    input  logic                      cfg_abort,
    input  logic                      cfg_valid,
    input  logic [SHIFT_W-1:0]        cfg_data,
    output logic                      cfg_ready,
    output logic                      cfg_done,
    output logic                      configured,
    input  logic [LUTS*ADDR_BITS-1:0] addr,
    output logic [LUTS-1:0]           out
);

    localparam int MEM_SIZE = 2 ** ADDR_BITS;
    localparam int TOTAL    = LUTS * MEM_SIZE;
    localparam int BEATS    = TOTAL / SHIFT_W;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] active;

    // New beat enters at the top; the oldest beat drifts down to bit 0.
    function automatic logic [TOTAL-1:0] shift_in(input logic [TOTAL-1:0] cur,
                                                  input logic [SHIFT_W-1:0] beat);
        logic [TOTAL+SHIFT_W-1:0] cat;
        cat = {beat, cur};
        return cat[TOTAL+SHIFT_W-1:SHIFT_W];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            shadow     <= '0;
            active     <= '0;
            cfg_ready  <= 1'b0;
            cfg_done   <= 1'b0;
            configured <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_done <= 1'b0;
                    if (cfg_en) begin
                        state     <= SHIFT;
                        beat_cnt  <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Abort wins over a beat presented in the same cycle.
                    if (cfg_abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b0;
                    end else if (cfg_valid) begin
                        shadow <= shift_in(shadow, cfg_data);
                        if (beat_cnt == LAST_BEAT) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                            cfg_done  <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    active     <= shadow;
                    configured <= 1'b1;
                    cfg_done   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    cfg_done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LUTS; i++) begin : g_lut
        logic [ADDR_BITS-1:0] a;
        assign a      = addr[i*ADDR_BITS +: ADDR_BITS];
        assign out[i] = active[i*MEM_SIZE + int'(a)];
    end

endmodule

// File: tb/tb_clb_config_chain.sv
// Directed bench for clb_config_chain with ADDR_BITS=2, LUTS=2, SHIFT_W=2.
module tb_clb_config_chain;

    logic       clk;
    logic       rst_n;
    logic       cfg_en;
    logic       cfg_abort;
    logic       cfg_valid;
    logic [1:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_done;
    logic       configured;
    logic [3:0] addr;
    logic [1:0] out;

    int errors = 0;
    int checks = 0;

    clb_config_chain #(.ADDR_BITS(2), .LUTS(2), .SHIFT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .cfg_abort  (cfg_abort),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .configured (configured),
        .addr       (addr),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sweep both channels across every address against an expected 8-bit image.
    task automatic chk_lut(input string tag, input logic [7:0] exp);
        logic [1:0] exp_out;
        for (int a = 0; a < 4; a++) begin
            addr = {2'(a), 2'(3 - a)};
            #1;
            exp_out = {exp[4 + a], exp[3 - a]};
            chk(tag, {6'b0, out}, {6'b0, exp_out});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        chk("ready_before_beat", {7'b0, cfg_ready}, 8'd1);
        cfg_valid = 1'b1;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 2'b00;
        addr      = 4'b1011;
        #2;
        chk("rst_ready", {7'b0, cfg_ready}, 8'd0);
        chk("rst_configured", {7'b0, configured}, 8'd0);
        chk("rst_done", {7'b0, cfg_done}, 8'd0);
        chk_lut("rst_out", 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;

        // Idle with a stray beat: no load starts
        cfg_valid = 1'b1;
        cfg_data  = 2'b11;
        tick();
        cfg_valid = 1'b0;
        chk("idle_ready", {7'b0, cfg_ready}, 8'd0);

        // First load -> 8'h39
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        send(2'b01);
        send(2'b10);
        send(2'b11);
        send(2'b00);
        chk("load1_done", {7'b0, cfg_done}, 8'd1);
        chk("load1_ready_commit", {7'b0, cfg_ready}, 8'd0);
        chk("load1_cfgd_commit", {7'b0, configured}, 8'd0);
        chk_lut("load1_out_commit", 8'h00);
        tick();
        chk("load1_done_pulse", {7'b0, cfg_done}, 8'd0);
        chk("load1_configured", {7'b0, configured}, 8'd1);
        chk_lut("load1_out", 8'h39);

        // Back-to-back load with cfg_en pulses during SHIFT -> 8'hC6
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        send(2'b10);
        cfg_en = 1'b1;
        send(2'b01);
        cfg_en = 1'b0;
        send(2'b00);
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        chk("b2b_no_early_done", {7'b0, cfg_done}, 8'd0);
        send(2'b11);
        chk("b2b_done", {7'b0, cfg_done}, 8'd1);
        tick();
        chk_lut("b2b_out", 8'hC6);

        // Stalled load -> 8'h39, outputs hold old image until after commit
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        send(2'b01);
        send(2'b10);
        repeat (3) begin
            tick();
            chk("stall_ready", {7'b0, cfg_ready}, 8'd1);
            chk("stall_done", {7'b0, cfg_done}, 8'd0);
        end
        chk_lut("stall_out_hold", 8'hC6);
        send(2'b11);
        send(2'b00);
        chk("stall_done_commit", {7'b0, cfg_done}, 8'd1);
        chk_lut("stall_out_commit", 8'hC6);
        tick();
        chk("stall_done_clear", {7'b0, cfg_done}, 8'd0);
        chk_lut("stall_out", 8'h39);

        // Abort after two beats, beat in abort cycle discarded
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        send(2'b11);
        send(2'b11);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 2'b11;
        tick();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_ready", {7'b0, cfg_ready}, 8'd0);
        chk("abort_no_done", {7'b0, cfg_done}, 8'd0);
        tick();
        chk("abort_no_done2", {7'b0, cfg_done}, 8'd0);
        chk_lut("abort_out", 8'h39);

        // Abort held in IDLE and COMMIT is ignored -> 8'h0F
        cfg_en    = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_en    = 1'b0;
        cfg_abort = 1'b0;
        chk("idle_abort_ignored", {7'b0, cfg_ready}, 8'd1);
        send(2'b11);
        send(2'b11);
        send(2'b00);
        send(2'b00);
        cfg_abort = 1'b1;
        chk("commit_abort_done", {7'b0, cfg_done}, 8'd1);
        tick();
        cfg_abort = 1'b0;
        chk("commit_abort_clear", {7'b0, cfg_done}, 8'd0);
        chk_lut("commit_abort_out", 8'h0F);

        // Reset mid-load, then a fresh full load -> 8'hFF
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        send(2'b11);
        send(2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {7'b0, cfg_ready}, 8'd0);
        chk("midrst_configured", {7'b0, configured}, 8'd0);
        chk_lut("midrst_out", 8'h00);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("midrst_wait_idle", {7'b0, cfg_ready}, 8'd0);
        chk("midrst_no_done", {7'b0, cfg_done}, 8'd0);
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        send(2'b11);
        send(2'b11);
        send(2'b11);
        send(2'b11);
        chk("ff_done", {7'b0, cfg_done}, 8'd1);
        tick();
        chk("ff_configured", {7'b0, configured}, 8'd1);
        chk_lut("ff_out", 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clb_config_chain.md
CLB_CONFIG_CHAIN -- requirements
Module: clb_config_chain

Interface
REQ-001 Parameter ADDR_BITS, default 4, LUT address width per channel.
REQ-002 Parameter LUTS, default 2, number of independent LUT channels.
REQ-003 Parameter SHIFT_W, default 1, config bits accepted per beat; LUTS*2**ADDR_BITS SHALL be a multiple of SHIFT_W.
REQ-004 Derived MEM_SIZE=2**ADDR_BITS, TOTAL=LUTS*MEM_SIZE, BEATS=TOTAL/SHIFT_W.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cfg_en  input  1  start-load request, sampled in IDLE.
REQ-008 cfg_abort  input  1  abandon load in progress.
REQ-009 cfg_valid  input  1  cfg_data beat valid.
REQ-010 cfg_data  input  SHIFT_W  config beat.
REQ-011 cfg_ready  output  1  block accepts a beat this cycle.
REQ-012 cfg_done  output  1  one-cycle pulse on commit.
REQ-013 configured  output  1  high once any commit has occurred since reset.
REQ-014 addr  input  LUTS*ADDR_BITS  channel i address at [i*ADDR_BITS +: ADDR_BITS].
REQ-015 out  output  LUTS  channel i LUT output.

Function
REQ-016 Storage SHALL be a TOTAL-bit shadow register and a TOTAL-bit active register; out SHALL read only the active register.
REQ-017 out[i] SHALL equal active[i*MEM_SIZE + addr_i], combinational, zero latency from addr.
REQ-018 FSM states SHALL be IDLE, SHIFT, COMMIT.
REQ-019 IDLE: cfg_ready=0; cfg_en=1 -> SHIFT next cycle, beat counter cleared to 0.
REQ-020 SHIFT: cfg_ready=1; a beat is accepted when cfg_valid & cfg_ready.
REQ-021 Each accepted beat: shadow <= {cfg_data, shadow[TOTAL-1:SHIFT_W]}; counter increments; the first beat ends in shadow[SHIFT_W-1:0].
REQ-022 Acceptance of beat BEATS-1 -> COMMIT next cycle; cfg_ready deasserts in that cycle.
REQ-023 COMMIT (exactly one cycle): active <= shadow, cfg_done=1, configured <= 1, then -> IDLE.
REQ-024 New out values SHALL be visible the cycle after COMMIT; out SHALL be unchanged during SHIFT.
REQ-025 cfg_abort=1 in SHIFT SHALL return to IDLE next cycle with active unchanged, no cfg_done; a beat presented in the same cycle is discarded.
REQ-026 cfg_abort in IDLE or COMMIT SHALL be ignored; COMMIT always completes.
REQ-027 cfg_en while in SHIFT or COMMIT SHALL be ignored.
REQ-028 cfg_valid=0 in SHIFT SHALL hold shadow and counter (arbitrary stalls allowed).
REQ-029 cfg_valid in IDLE SHALL not alter shadow.
REQ-030 cfg_en=1 in the IDLE cycle immediately after COMMIT SHALL start a new load normally.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, shadow 0, active 0, cfg_ready 0, cfg_done 0, configured 0, hence out 0.
REQ-032 Reset asserted mid-SHIFT SHALL discard partial data; after release the block waits in IDLE for cfg_en.

Verification (ADDR_BITS=2, LUTS=2, SHIFT_W=2: TOTAL=8, BEATS=4)
REQ-033 Reset: rst_n low, any addr -> out=2'b00, cfg_ready=0, configured=0.
REQ-034 Load: cfg_en, then beats 01,10,11,00 -> cfg_done pulse one cycle, active=8'h39; LUT0=4'b1001, LUT1=4'b0011; addr0=0 -> out[0]=1, addr0=1 -> out[0]=0, addr1=1 -> out[1]=1, addr1=2 -> out[1]=0.
REQ-035 Stall: same beats with cfg_valid low 3 cycles between beats 2 and 3 -> identical active=8'h39; out unchanged until the cycle after COMMIT.
REQ-036 Abort: after active=8'h39, load 2 beats of 11 then cfg_abort -> IDLE, no cfg_done, active stays 8'h39.
REQ-037 Mid-load reset: assert rst_n low after 2 beats -> active=0, configured=0; new full load of 11,11,11,11 -> active=8'hFF.
REQ-038 Back-to-back: cfg_en in the cycle after cfg_done -> second load accepted; cfg_en pulses during SHIFT have no effect on the counter.
